// File: rtl/frame_ctrl_pkg.sv
// Shared types and kernel constants for the frame controller.
// Kernels are stored as nine signed 2-bit taps, index r*3+c.
package frame_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_IDENT     = 2'd0,
        MODE_BOX       = 2'd1,
        MODE_PREWITT_X = 2'd2,
        MODE_PREWITT_Y = 2'd3
    } mode_e;

    typedef enum logic {
        FS_IDLE   = 1'b0,
        FS_ACTIVE = 1'b1
    } frame_state_e;

    typedef logic signed [1:0] tap_t;
    typedef tap_t [8:0] kernel_t;

    // Concatenations list tap 8 (r2,c2) first, tap 0 (r0,c0) last.
    localparam kernel_t KERNEL_IDENT = {2'b00, 2'b00, 2'b00,
                                        2'b00, 2'b01, 2'b00,
                                        2'b00, 2'b00, 2'b00};
    localparam kernel_t KERNEL_BOX   = {2'b01, 2'b01, 2'b01,
                                        2'b01, 2'b01, 2'b01,
                                        2'b01, 2'b01, 2'b01};
    localparam kernel_t KERNEL_PREWITT_X = {2'b01, 2'b00, 2'b11,
                                            2'b01, 2'b00, 2'b11,
                                            2'b01, 2'b00, 2'b11};
    localparam kernel_t KERNEL_PREWITT_Y = {2'b01, 2'b01, 2'b01,
                                            2'b00, 2'b00, 2'b00,
                                            2'b11, 2'b11, 2'b11};

    function automatic kernel_t kernel_lut(input mode_e m);
        kernel_t k;
        case (m)
            MODE_IDENT:     k = KERNEL_IDENT;
            MODE_BOX:       k = KERNEL_BOX;
            MODE_PREWITT_X: k = KERNEL_PREWITT_X;
            MODE_PREWITT_Y: k = KERNEL_PREWITT_Y;
            default:        k = KERNEL_IDENT;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/frame_ctrl_if.sv
// Observed pixel handshake into the convolution datapath plus the
// position markers derived from it.
interface frame_ctrl_if;
    logic pix_valid_i;
    logic pix_ready_i;
    logic sof_o;
    logic eol_o;
    logic eof_o;

    modport master (output pix_valid_i, pix_ready_i, input sof_o, eol_o, eof_o);
    modport slave  (input pix_valid_i, pix_ready_i, output sof_o, eol_o, eof_o);
endinterface

// File: rtl/frame_ctrl_edge_detect.sv
// Per-bit registered rising-edge detector. The first cycle after reset is
// used only to capture history, so a level held through reset gives no event.
module edge_detect #(
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] level_i,
    output logic [Width-1:0] rise_o
);

    logic [Width-1:0] r_prev;
    logic [Width-1:0] r_rise;
    logic             r_armed;

    // History capture and one-cycle event pulse generation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prev  <= '0;
            r_rise  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= level_i;
            r_rise  <= level_i & ~r_prev & {Width{r_armed}};
            r_armed <= 1'b1;
        end
    end

    assign rise_o = r_rise;

endmodule

// File: rtl/frame_ctrl.sv
// Frame-level controller: pixel position tracking, frame-boundary kernel and
// bypass selection from buttons, and UART RTS hysteresis.
module frame_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int unsigned ImageWidth   = 320,
    parameter int unsigned ImageHeight  = 240,
    parameter int unsigned KernelWidth  = 3,
    parameter int unsigned WeightWidth  = 2,
    parameter int unsigned FifoDepth    = 16,
    parameter int unsigned RtsHighWater = 12,
    parameter int unsigned RtsLowWater  = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [2:0]                                    button_i,
    input  logic [$clog2(FifoDepth+1)-1:0]                fifo_count_i,
    frame_ctrl_if.slave                                   pix_if,
    output logic [1:0]                                    mode_o,
    output logic [KernelWidth*KernelWidth*WeightWidth-1:0] weights_o,
    output logic                                          bypass_o,
    output logic                                          uart_rts_o,
    output logic [4:0]                                    led_o,
    output logic                                          busy_o
);

    localparam int unsigned ColW    = $clog2(ImageWidth);
    localparam int unsigned RowW    = $clog2(ImageHeight);
    localparam int unsigned CntW    = $clog2(FifoDepth + 1);
    localparam int unsigned NumTaps = KernelWidth * KernelWidth;
    localparam int unsigned WgtW    = NumTaps * WeightWidth;

    if (KernelWidth != 3) begin : g_bad_kernel_width
        $error("frame_ctrl: KernelWidth must be 3");
    end
    if (WeightWidth < 2) begin : g_bad_weight_width
        $error("frame_ctrl: WeightWidth must be at least 2");
    end
    if (RtsLowWater >= RtsHighWater) begin : g_bad_watermarks
        $error("frame_ctrl: RtsLowWater must be below RtsHighWater");
    end

    // Taps are -1/0/+1, so sign-extension is replicating bit 1 above bit 0.
    function automatic logic [WgtW-1:0] expand(input kernel_t k);
        logic [WgtW-1:0] w;
        w = '0;
        for (int i = 0; i < NumTaps; i++) begin
            w[i*WeightWidth +: WeightWidth] = {{(WeightWidth-1){k[i][1]}}, k[i][0]};
        end
        return w;
    endfunction

    logic [2:0]      w_evt;
    frame_state_e    r_state, w_state_nxt;
    logic [ColW-1:0] r_col, w_col_nxt;
    logic [RowW-1:0] r_row, w_row_nxt;
    logic [1:0]      r_tmode, w_tmode_nxt, r_mode;
    logic            r_tbyp, w_tbyp_nxt, r_bypass;
    logic [WgtW-1:0] r_weights, w_weights_nxt;
    logic            r_rts, w_rts_nxt, r_hb;
    logic            w_beat, w_restart, w_beat_acc;
    logic            w_sof, w_eol, w_eof, w_eof_beat, w_apply;

    edge_detect #(.Width(3)) u_buttons (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .level_i (button_i),
        .rise_o  (w_evt)
    );

    // A restart event pre-empts a beat accepted in the same cycle.
    assign w_restart  = w_evt[2];
    assign w_beat     = pix_if.pix_valid_i & pix_if.pix_ready_i;
    assign w_beat_acc = w_beat & ~w_restart;
    assign w_sof      = (r_col == '0) && (r_row == '0);
    assign w_eol      = (r_col == ColW'(ImageWidth - 1));
    assign w_eof      = w_eol && (r_row == RowW'(ImageHeight - 1));
    assign w_eof_beat = w_beat_acc & w_eof;
    assign w_apply    = (r_state == FS_IDLE) | w_eof_beat | w_restart;

    // Frame state next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FS_IDLE: begin
                if (w_restart) begin
                    w_state_nxt = FS_IDLE;
                end else if (w_beat_acc) begin
                    w_state_nxt = w_eof ? FS_IDLE : FS_ACTIVE;
                end else begin
                    w_state_nxt = FS_IDLE;
                end
            end
            FS_ACTIVE: begin
                if (w_restart || w_eof_beat) begin
                    w_state_nxt = FS_IDLE;
                end else begin
                    w_state_nxt = FS_ACTIVE;
                end
            end
            default: w_state_nxt = FS_IDLE;
        endcase
    end

    // Column/row position next values.
    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (w_restart) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (w_beat_acc) begin
            if (w_eol) begin
                w_col_nxt = '0;
                w_row_nxt = w_eof ? '0 : r_row + RowW'(1);
            end else begin
                w_col_nxt = r_col + ColW'(1);
            end
        end else begin
            w_col_nxt = r_col;
        end
    end

    // Pending configuration, kernel lookup and RTS hysteresis.
    always_comb begin
        w_tmode_nxt   = r_tmode + {1'b0, w_evt[0]};
        w_tbyp_nxt    = r_tbyp ^ w_evt[1];
        w_weights_nxt = expand(kernel_lut(mode_e'(w_tmode_nxt)));
        if (fifo_count_i >= CntW'(RtsHighWater)) begin
            w_rts_nxt = 1'b1;
        end else if (fifo_count_i <= CntW'(RtsLowWater)) begin
            w_rts_nxt = 1'b0;
        end else begin
            w_rts_nxt = r_rts;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Position, configuration, RTS and heartbeat registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_col     <= '0;
            r_row     <= '0;
            r_tmode   <= 2'd0;
            r_tbyp    <= 1'b0;
            r_mode    <= 2'd0;
            r_bypass  <= 1'b0;
            r_weights <= expand(KERNEL_IDENT);
            r_rts     <= 1'b0;
            r_hb      <= 1'b0;
        end else begin
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_tmode <= w_tmode_nxt;
            r_tbyp  <= w_tbyp_nxt;
            r_rts   <= w_rts_nxt;
            if (w_apply) begin
                r_mode    <= w_tmode_nxt;
                r_bypass  <= w_tbyp_nxt;
                r_weights <= w_weights_nxt;
            end
            if (w_eof_beat) begin
                r_hb <= ~r_hb;
            end
        end
    end

    assign pix_if.sof_o = w_sof;
    assign pix_if.eol_o = w_eol;
    assign pix_if.eof_o = w_eof;
    assign mode_o       = r_mode;
    assign weights_o    = r_weights;
    assign bypass_o     = r_bypass;
    assign uart_rts_o   = r_rts;
    assign busy_o       = (r_state == FS_ACTIVE);
    // led_o[0]=RTS, [2:1]=mode, [3]=bypass, [4]=frame heartbeat
    assign led_o        = {r_hb, r_bypass, r_mode, r_rts};

endmodule

// File: tb/tb_frame_ctrl.sv
// Self-checking bench for frame_ctrl using a reduced 64x24 frame so several
// complete frames fit in a short run.
module tb_frame_ctrl;
    import frame_ctrl_pkg::*;

    localparam int W = 64;
    localparam int H = 24;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  button;
    logic [4:0]  fifo_count;
    logic [1:0]  mode;
    logic [17:0] weights;
    logic        bypass, rts, busy;
    logic [4:0]  led;

    int n_cmp = 0;
    int n_bad = 0;

    frame_ctrl_if pif ();

    frame_ctrl #(.ImageWidth(W), .ImageHeight(H)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .button_i     (button),
        .fifo_count_i (fifo_count),
        .pix_if       (pif),
        .mode_o       (mode),
        .weights_o    (weights),
        .bypass_o     (bypass),
        .uart_rts_o   (rts),
        .led_o        (led),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] btn;
        int         mode;
        int         byp;
    } cfg_vec_t;

    typedef struct {
        logic [4:0] cnt;
        logic       rts;
    } rts_vec_t;

    cfg_vec_t cv[12];
    rts_vec_t rv[33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] exp_weights(input int m);
        int t[9];
        logic [17:0] w;
        case (m)
            0:       t = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
            1:       t = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
            2:       t = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
            default: t = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
        endcase
        w = '0;
        for (int i = 0; i < 9; i++) w[i*2 +: 2] = 2'(t[i]);
        return w;
    endfunction

    task automatic check_cfg(input string tag, input int m, input int b);
        check({tag, ".mode"},    32'(mode), 32'(m));
        check({tag, ".bypass"},  32'(bypass), 32'(b));
        check({tag, ".weights"}, 32'(weights), 32'(exp_weights(m)));
        check({tag, ".led_mode"}, 32'(led[2:1]), 32'(m));
        check({tag, ".led_byp"},  32'(led[3]), 32'(b));
    endtask

    // Streams one frame; checks markers on every accepted beat and that the
    // active mode holds at mode_hold until the frame ends.
    task automatic run_frame(input int press_beat, input int mode_hold, input bit gaps);
        int k = 0;
        int cyc = 0;
        bit v, r;
        check("frame_start.busy", 32'(busy), 32'd0);
        while (k < N && cyc < 20 * N) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            pif.pix_valid_i = v;
            pif.pix_ready_i = r;
            button[0] = (press_beat >= 0) && (k == press_beat);
            if (v && r) begin
                check($sformatf("beat%0d.eol", k), 32'(pif.eol_o), 32'((k % W) == W - 1));
                check($sformatf("beat%0d.eof", k), 32'(pif.eof_o), 32'(k == N - 1));
                check($sformatf("beat%0d.sof", k), 32'(pif.sof_o), 32'(k == 0));
                check($sformatf("beat%0d.mode", k), 32'(mode), 32'(mode_hold));
                if (k > 0) check($sformatf("beat%0d.busy", k), 32'(busy), 32'd1);
                k++;
            end
            tick();
            cyc++;
        end
        pif.pix_valid_i = 1'b0;
        pif.pix_ready_i = 1'b0;
        button[0] = 1'b0;
        if (k < N) check("frame_timeout.beats", 32'(k), 32'(N));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        button = 3'b001;
        fifo_count = 5'd0;
        pif.pix_valid_i = 1'b0;
        pif.pix_ready_i = 1'b0;

        #12;
        check("rst.sof", 32'(pif.sof_o), 32'd1);
        check("rst.eol", 32'(pif.eol_o), 32'd0);
        check("rst.eof", 32'(pif.eof_o), 32'd0);
        check("rst.rts", 32'(rts), 32'd0);
        check("rst.led", 32'(led), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check_cfg("rst", 0, 0);

        // Next-mode button held through reset release must not count.
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("held_through_reset.mode", 32'(mode), 32'd0);
        button = 3'b000;
        repeat (2) tick();

        cv[0]  = '{3'b001, 1, 0};
        cv[1]  = '{3'b001, 2, 0};
        cv[2]  = '{3'b001, 3, 0};
        cv[3]  = '{3'b010, 3, 1};
        cv[4]  = '{3'b001, 0, 1};
        cv[5]  = '{3'b001, 1, 1};
        cv[6]  = '{3'b010, 1, 0};
        cv[7]  = '{3'b001, 2, 0};
        cv[8]  = '{3'b001, 3, 0};
        cv[9]  = '{3'b001, 0, 0};
        cv[10] = '{3'b011, 1, 1};
        cv[11] = '{3'b011, 2, 0};
        for (int i = 0; i < 12; i++) begin
            int pm;
            pm = (i == 0) ? 0 : cv[i-1].mode;
            button = cv[i].btn;
            tick();
            check($sformatf("cfg%0d.latency_mode", i), 32'(mode), 32'(pm));
            button = 3'b000;
            tick();
            check_cfg($sformatf("cfg%0d", i), cv[i].mode, cv[i].byp);
        end

        // Long hold is one event: 2 -> 3, then one press wraps to 0.
        button[0] = 1'b1;
        repeat (6) tick();
        button[0] = 1'b0;
        tick();
        check("hold.mode", 32'(mode), 32'd3);
        button[0] = 1'b1;
        tick();
        button[0] = 1'b0;
        tick();
        check_cfg("wrap", 0, 0);

        // Full frame with gaps, next-mode press mid-frame at beat 1000.
        run_frame(1000, 0, 1'b1);
        check_cfg("frame1_end", 1, 0);
        check("frame1_end.busy", 32'(busy), 32'd0);
        check("frame1_end.heartbeat", 32'(led[4]), 32'd1);
        check("frame1_end.sof", 32'(pif.sof_o), 32'd1);

        // Restart event coincides with the beat at col 50, row 7.
        pif.pix_valid_i = 1'b1;
        pif.pix_ready_i = 1'b1;
        for (int k = 0; k < 7 * W + 50; k++) begin
            button[1] = (k == 100);
            button[2] = (k == 7 * W + 49);
            tick();
        end
        button = 3'b000;
        check("pre_restart.busy", 32'(busy), 32'd1);
        check("pre_restart.sof", 32'(pif.sof_o), 32'd0);
        check("pre_restart.bypass", 32'(bypass), 32'd0);
        tick();
        pif.pix_valid_i = 1'b0;
        pif.pix_ready_i = 1'b0;
        check("restart.sof", 32'(pif.sof_o), 32'd1);
        check("restart.eol", 32'(pif.eol_o), 32'd0);
        check("restart.busy", 32'(busy), 32'd0);
        check("restart.heartbeat", 32'(led[4]), 32'd1);
        check_cfg("restart", 1, 1);
        run_frame(-1, 1, 1'b0);
        check("frame2_end.heartbeat", 32'(led[4]), 32'd0);
        check("frame2_end.busy", 32'(busy), 32'd0);

        // RTS ramp 0 -> 16 -> 0.
        for (int i = 0; i <= 16; i++) rv[i] = '{5'(i), 1'(i >= 12)};
        for (int i = 17; i < 33; i++) rv[i] = '{5'(32 - i), 1'((32 - i) >= 5)};
        for (int i = 0; i < 33; i++) begin
            logic prev;
            prev = (i == 0) ? 1'b0 : rv[i-1].rts;
            fifo_count = rv[i].cnt;
            #1;
            check($sformatf("rts%0d.before_edge", i), 32'(rts), 32'(prev));
            tick();
            check($sformatf("rts%0d.cnt%0d", i, rv[i].cnt), 32'(rts), 32'(rv[i].rts));
            check($sformatf("rts%0d.led", i), 32'(led[0]), 32'(rv[i].rts));
        end

        // Asynchronous reset mid-frame with target mode 2 pending.
        fifo_count = 5'd14;
        repeat (2) tick();
        check("pre_reset.rts", 32'(rts), 32'd1);
        pif.pix_valid_i = 1'b1;
        pif.pix_ready_i = 1'b1;
        repeat (200) tick();
        button[0] = 1'b1;
        tick();
        button[0] = 1'b0;
        tick();
        check("pending.mode", 32'(mode), 32'd1);
        check("pending.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.rts", 32'(rts), 32'd0);
        check("midreset.led", 32'(led), 32'd0);
        check("midreset.sof", 32'(pif.sof_o), 32'd1);
        check_cfg("midreset", 0, 0);
        fifo_count = 5'd0;
        pif.pix_valid_i = 1'b0;
        pif.pix_ready_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        run_frame(-1, 0, 1'b1);
        check_cfg("after_reset_frame", 0, 0);
        check("after_reset_frame.heartbeat", 32'(led[4]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
